// File: rtl/pattern_serializer_pkg.sv
// Shared definitions for the pattern serializer: FSM state encoding and
// helpers that size the bit-index and divider counters.
package ser_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    localparam int WIDTH_DEF = 16;
    localparam int DIV_DEF   = 1;

    // Counter width for a modulus of n; a modulus of 1 still needs one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int BIT_W_DEF = cnt_w(WIDTH_DEF);
    localparam int DIV_W_DEF = cnt_w(DIV_DEF);

endpackage

// File: rtl/pattern_serializer_if.sv
// Handshake and stream signals between a word source (master) and the
// serializer (slave).
interface pattern_serializer_if #(
    parameter int WIDTH = 16
);
    import ser_pkg::*;

    localparam int BIT_W = cnt_w(WIDTH);

    logic             load;
    logic [WIDTH-1:0] data;
    logic             abort;
    logic             ready;
    logic             ser_out;
    logic             bit_stb;
    logic             done;
    logic [BIT_W-1:0] bit_idx;

    modport master (
        output load, data, abort,
        input  ready, ser_out, bit_stb, done, bit_idx
    );

    modport slave (
        input  load, data, abort,
        output ready, ser_out, bit_stb, done, bit_idx
    );

endinterface

// File: rtl/pattern_serializer_tick_gen.sv
// Bit-period enable: counts 0..DIV-1 and flags the last cycle of each bit.
// Held at zero while i_clear is high so every word starts on a full period.
module tick_gen
    import ser_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick
);
    localparam int DIV_W = cnt_w(DIV);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;

    // Divider counter: wraps after DIV cycles, restarts on clear or reset.
    always_ff @(posedge clk) begin
        if (reset || i_clear || (r_div_cnt == LAST)) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    assign o_tick = !i_clear && (r_div_cnt == LAST);

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-to-serial stimulus stage: shifts a captured word out MSB-first,
// one bit per DIV clocks, with a strobe on every new bit and a done pulse
// after the final bit.
// Optional feature macro: SER_LOOP_EN -- repeat the captured word forever
// (until abort or reset) instead of returning to IDLE after one pass.
module pattern_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIV   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    pattern_serializer_if.slave  bus
);
    localparam int BIT_W = cnt_w(WIDTH);
    localparam logic [BIT_W-1:0] MSB_IDX = BIT_W'(WIDTH - 1);

    ser_state_t       r_state;
    logic [WIDTH-1:0] r_shreg;
`ifdef SER_LOOP_EN
    logic [WIDTH-1:0] r_word;
`endif
    logic [BIT_W-1:0] r_bit_idx;
    logic             r_ser_out;
    logic             r_bit_stb;
    logic             r_done;
    logic             r_ready;

    logic             w_clear;
    logic             w_tick;

    // The divider only runs while a word is in flight and not being aborted.
    assign w_clear = (r_state == ST_IDLE) || bus.abort;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    // Control FSM, shift register and bit counter with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
`ifdef SER_LOOP_EN
            r_word    <= '0;
`endif
            r_bit_idx <= '0;
            r_ser_out <= 1'b0;
            r_bit_stb <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_bit_stb <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Load beats a simultaneous abort; abort alone does nothing here.
                    if (bus.load && r_ready) begin
                        r_state   <= ST_SHIFT;
                        r_shreg   <= bus.data;
`ifdef SER_LOOP_EN
                        r_word    <= bus.data;
`endif
                        r_ser_out <= bus.data[WIDTH-1];
                        r_bit_stb <= 1'b1;
                        r_bit_idx <= MSB_IDX;
                        r_ready   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (bus.abort) begin
                        r_state   <= ST_IDLE;
                        r_ser_out <= 1'b0;
                        r_bit_idx <= '0;
                        r_ready   <= 1'b1;
                    end else if (w_tick) begin
                        if (r_bit_idx == '0) begin
                            r_done    <= 1'b1;
`ifdef SER_LOOP_EN
                            // Restart at the MSB with no idle gap.
                            r_shreg   <= r_word;
                            r_ser_out <= r_word[WIDTH-1];
                            r_bit_stb <= 1'b1;
                            r_bit_idx <= MSB_IDX;
`else
                            r_state   <= ST_IDLE;
                            r_ser_out <= 1'b0;
                            r_ready   <= 1'b1;
`endif
                        end else begin
                            r_shreg   <= r_shreg << 1;
                            r_ser_out <= r_shreg[WIDTH-2];
                            r_bit_stb <= 1'b1;
                            r_bit_idx <= r_bit_idx - BIT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready   = r_ready;
    assign bus.ser_out = r_ser_out;
    assign bus.bit_stb = r_bit_stb;
    assign bus.done    = r_done;
    assign bus.bit_idx = r_bit_idx;

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: one WIDTH=8/DIV=1 instance and one
// WIDTH=8/DIV=3 instance. Inputs change and outputs are sampled on the
// falling edge; "cycle c" is the c-th falling edge after the load edge.
module tb_pattern_serializer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pattern_serializer_if #(.WIDTH(8)) if1 ();
    pattern_serializer_if #(.WIDTH(8)) if3 ();

    pattern_serializer #(.WIDTH(8), .DIV(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    pattern_serializer #(.WIDTH(8), .DIV(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Expected output vector: {ser_out, bit_stb, done, ready, bit_idx}.
    function automatic logic [6:0] pack(input logic s, input logic b, input logic d,
                                        input logic r, input logic [2:0] i);
        return {s, b, d, r, i};
    endfunction

    function automatic logic [6:0] obs1();
        return {if1.ser_out, if1.bit_stb, if1.done, if1.ready, if1.bit_idx};
    endfunction

    function automatic logic [6:0] obs3();
        return {if3.ser_out, if3.bit_stb, if3.done, if3.ready, if3.bit_idx};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed={ser,stb,done,rdy,idx}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Check cycles 1..8 of a DIV=1 word on dut1; load must already be driven.
    task automatic stream1(input logic [7:0] w, input string tag);
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (c == 1) if1.load = 1'b0;
            chk($sformatf("%s c%0d", tag, c), obs1(), pack(w[8-c], 1'b1, 1'b0, 1'b0, 3'(8-c)));
        end
    endtask

    initial begin
        reset     = 1'b1;
        if1.load  = 1'b0; if1.data = '0; if1.abort = 1'b0;
        if3.load  = 1'b0; if3.data = '0; if3.abort = 1'b0;

        // 1: reset held two cycles
        cyc(); cyc();
        chk("t1 reset dut1", obs1(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
        chk("t1 reset dut3", obs3(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
        reset = 1'b0;
        cyc();
        chk("t1 idle dut1", obs1(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
        $display("test1 reset values checked");

`ifndef SER_LOOP_EN
        // 2: F0 at DIV=1, then a back-to-back load of 3C in the done cycle
        if1.load = 1'b1; if1.data = 8'hF0;
        stream1(8'hF0, "t2 F0");
        cyc();
        chk("t2 done c9", obs1(), pack(1'b0, 1'b0, 1'b1, 1'b1, 3'd0));
        if1.load = 1'b1; if1.data = 8'h3C;
        stream1(8'h3C, "t2 3C");
        cyc();
        chk("t2 3C done", obs1(), pack(1'b0, 1'b0, 1'b1, 1'b1, 3'd0));
        cyc();
        chk("t2 3C idle", obs1(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
        $display("test2 words F0 and 3C streamed");

        // 3: A5 at DIV=3, strobe on the first of every three cycles
        begin
            logic [7:0] w3;
            w3 = 8'hA5;
            if3.load = 1'b1; if3.data = w3;
            for (int c = 1; c <= 24; c++) begin
                int i;
                cyc();
                if (c == 1) if3.load = 1'b0;
                i = (c - 1) / 3;
                chk($sformatf("t3 A5 c%0d", c), obs3(),
                    pack(w3[7-i], ((c - 1) % 3) == 0, 1'b0, 1'b0, 3'(7-i)));
            end
            cyc();
            chk("t3 done c25", obs3(), pack(1'b0, 1'b0, 1'b1, 1'b1, 3'd0));
            cyc();
            chk("t3 idle c26", obs3(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
        end
        $display("test3 word A5 streamed at DIV=3");
`endif

        // 4: 0F with an ignored FF load at cycle 3, abort at cycle 5
        begin
            logic [7:0] w4;
            w4 = 8'h0F;
            if1.load = 1'b1; if1.data = w4;
            for (int c = 1; c <= 5; c++) begin
                cyc();
                if1.load = 1'b0;
                if (c == 3) begin
                    if1.load = 1'b1; if1.data = 8'hFF;
                end
                chk($sformatf("t4 0F c%0d", c), obs1(), pack(w4[8-c], 1'b1, 1'b0, 1'b0, 3'(8-c)));
            end
            if1.abort = 1'b1;
            cyc();
            if1.abort = 1'b0;
            chk("t4 abort c6", obs1(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
            for (int c = 7; c <= 9; c++) begin
                cyc();
                chk($sformatf("t4 no done c%0d", c), obs1(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
            end
        end
        $display("test4 ignored reload and abort checked");

        // abort alone in IDLE does nothing; abort with load in IDLE loads
        if1.abort = 1'b1;
        cyc();
        chk("idle abort", obs1(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
        if1.load = 1'b1; if1.data = 8'h81;
        cyc();
        if1.load = 1'b0; if1.abort = 1'b0;
        chk("abort+load", obs1(), pack(1'b1, 1'b1, 1'b0, 1'b0, 3'd7));
        if1.abort = 1'b1;
        cyc();
        if1.abort = 1'b0;
        chk("abort 81", obs1(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
        $display("abort priority checked");

        // 5: reset mid-word, then a fresh word
        begin
            logic [7:0] w5;
            w5 = 8'h5A;
            if1.load = 1'b1; if1.data = w5;
            for (int c = 1; c <= 4; c++) begin
                cyc();
                if1.load = 1'b0;
                chk($sformatf("t5 5A c%0d", c), obs1(), pack(w5[8-c], 1'b1, 1'b0, 1'b0, 3'(8-c)));
            end
            reset = 1'b1;
            cyc();
            reset = 1'b0;
            chk("t5 reset dut1", obs1(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
            chk("t5 reset dut3", obs3(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
            if1.load = 1'b1; if1.data = 8'h96;
            stream1(8'h96, "t5 96");
            cyc();
`ifdef SER_LOOP_EN
            chk("t5 96 c9", obs1(), pack(1'b1, 1'b1, 1'b1, 1'b0, 3'd7));
`else
            chk("t5 96 c9", obs1(), pack(1'b0, 1'b0, 1'b1, 1'b1, 3'd0));
`endif
            if1.abort = 1'b1;
            cyc();
            if1.abort = 1'b0;
            chk("t5 idle", obs1(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
        end
        $display("test5 mid-word reset and fresh word checked");

`ifdef SER_LOOP_EN
        // 6: C3 repeats with no gap, done at the start of every repeat
        begin
            logic [7:0] w6;
            w6 = 8'hC3;
            if1.load = 1'b1; if1.data = w6;
            for (int c = 1; c <= 25; c++) begin
                int p;
                cyc();
                if1.load = 1'b0;
                p = (c - 1) % 8;
                chk($sformatf("t6 C3 c%0d", c), obs1(),
                    pack(w6[7-p], 1'b1, (c > 8) && (p == 0), 1'b0, 3'(7-p)));
            end
            if1.abort = 1'b1;
            cyc();
            if1.abort = 1'b0;
            chk("t6 abort", obs1(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
        end
        $display("test6 looping word C3 checked");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
